accumulator8: RTL and testbench

//   Running-sum register for the sample datapath.
//   - Each rising clock edge adds the input byte to an internal unsigned accumulator.
//   - The accumulator is presented directly as the output.
//   - A sticky overflow flag records that the sum has exceeded the register range.
//   - Sits between a byte-wide data source and downstream consumers of the running total.

---
 rtl/accumulator8.sv | 43 ++++
 tb/tb_accumulator8.sv | 128 ++++++++++++
 2 files changed

// File: rtl/accumulator8.sv
// Running-sum byte accumulator with sticky overflow flag.
// Define ACC_SATURATE_EN to clamp at all-ones instead of wrapping.
module accumulator8 #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [0:WIDTH-1] din,
  output logic [0:WIDTH-1] dout,
  output logic             ovf
);

  logic [0:WIDTH-1] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum;
  logic             carry;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, din};
    carry = sum[WIDTH];
    ovf_d = ovf_q | carry;
`ifdef ACC_SATURATE_EN
    acc_d = carry ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    acc_d = sum[WIDTH-1:0];
`endif
  end

  // Reset wins over accumulation; din is ignored on a reset edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign dout = acc_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_accumulator8.sv
// Directed and random checks for accumulator8.
// Expected values follow ACC_SATURATE_EN when it is defined.
module tb_accumulator8;

  logic       clock;
  logic       reset;
  logic [0:7] din;
  logic [0:7] dout;
  logic       ovf;

  int tests;
  int fails;
  int model;
  logic model_ovf;

  accumulator8 #(.WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .din   (din),
    .dout  (dout),
    .ovf   (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input logic r, input logic [7:0] d);
    reset = r;
    din   = d;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    din   = 8'hFF;

    // reset for two edges with din=FF
    step(1'b1, 8'hFF);
    step(1'b1, 8'hFF);
    check("reset_dout", dout, 8'd0);
    check("reset_ovf", {7'd0, ovf}, 8'd0);

    // basic sum
    step(1'b0, 8'd3);
    check("sum_3", dout, 8'd3);
    step(1'b0, 8'd5);
    check("sum_8", dout, 8'd8);
    step(1'b0, 8'd10);
    check("sum_18", dout, 8'd18);
    check("sum_ovf", {7'd0, ovf}, 8'd0);

    // din=0 holds
    step(1'b0, 8'd0);
    check("hold_0", dout, 8'd18);

    // exact boundary 255 is not overflow
    step(1'b0, 8'd237);
    check("edge_255", dout, 8'd255);
    check("edge_ovf", {7'd0, ovf}, 8'd0);

    // bring acc to 250
    step(1'b1, 8'd0);
    step(1'b0, 8'd250);
    check("pre_250", dout, 8'd250);

    step(1'b0, 8'd10);
`ifdef ACC_SATURATE_EN
    check("sat_dout", dout, 8'd255);
    check("sat_ovf", {7'd0, ovf}, 8'd1);
    step(1'b0, 8'd7);
    check("sat_hold", dout, 8'd255);
    check("sat_ovf2", {7'd0, ovf}, 8'd1);
`else
    check("wrap_dout", dout, 8'd4);
    check("wrap_ovf", {7'd0, ovf}, 8'd1);
    step(1'b0, 8'd1);
    check("wrap_next", dout, 8'd5);
    check("wrap_sticky", {7'd0, ovf}, 8'd1);
`endif

    // reset priority mid-stream, also clears ovf
    step(1'b1, 8'd0);
    step(1'b0, 8'd100);
    check("pre_100", dout, 8'd100);
    step(1'b1, 8'd20);
    check("rstpri_dout", dout, 8'd0);
    check("rstpri_ovf", {7'd0, ovf}, 8'd0);
    step(1'b0, 8'd20);
    check("resume_20", dout, 8'd20);

    // random soak against reference model
    model = 20;
    model_ovf = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      step(1'b0, d);
      model = model + int'(d);
      if (model > 255) begin
        model_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
        model = 255;
`else
        model = model - 256;
`endif
      end
      check("soak_dout", dout, 8'(model));
      check("soak_ovf", {7'd0, ovf}, {7'd0, model_ovf});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
